// File: rtl/nand_serial_seq.sv
// ---------------------------------------------------------------------------
// nand_serial_seq
//
// Bit-serial logic micro-sequencer. A W-bit bitwise result is produced by
// one shared 1-bit NAND gate. The gate is time-multiplexed: operand bits and
// intermediate terms are steered into it, LSB first, with one gate evaluation
// per clock.
//
// Optional feature macro: NAND_SEQ_OPSEL_EN
//   undefined : NAND only, one step per bit, no op port, no t2/t3 registers.
//   defined   : adds a 2-bit op port (00 NAND, 01 AND, 10 OR, 11 XOR) that
//               is captured with a/b. Every function is built from the same
//               gate using temporaries t1..t3, at 1/2/3/4 steps per bit.
//
// Ports:
//   clk    in   1  system clock, rising edge
//   rst    in   1  synchronous reset, active high
//   start  in   1  request; sampled only while idle
//   a, b   in   W  operands, captured on the accepting edge
//   op     in   2  operation select (only with NAND_SEQ_OPSEL_EN)
//   busy   out  1  high while the operation runs
//   done   out  1  one-cycle pulse, result is final
//   result out  W  last completed result, held until the next completion
//
// Timing: the capture edge is edge 0. done and the new result appear after
// edge W*S, and the next start is accepted at edge W*S+2.
// ---------------------------------------------------------------------------

// Single 1-bit NAND gate; the only logic element in the datapath.
module nand_gate (
    input  logic x,
    input  logic y,
    output logic z
);
    assign z = ~(x & y);
endmodule

// Handshake sanity properties, kept out of the design module.
module nand_serial_seq_chk (
    input logic clk,
    input logic rst,
    input logic busy,
    input logic done
);
    // done and busy are mutually exclusive states of the sequencer
    a_busy_done_excl: assert property (@(posedge clk) disable iff (rst) !(busy && done));

    // done must be a single-cycle pulse
    a_done_pulse: assert property (@(posedge clk) disable iff (rst) done |=> !done);
endmodule

module nand_serial_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
`ifdef NAND_SEQ_OPSEL_EN
    input  logic [1:0]   op,
`endif
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result
);

    // A 1-bit index is kept for W=1 so the index register is never zero-width.
    localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic [IDX_W-1:0]   idx_r;
    logic [1:0]         step_r;
    logic [W-1:0]       shadow_r;
    logic [W-1:0]       result_r;
    logic               busy_r;
    logic               done_r;

    logic               bit_a_s;
    logic               bit_b_s;
    logic               gate_x_s;
    logic               gate_y_s;
    logic               gate_z_s;
    logic               last_step_s;
    logic [W-1:0]       shadow_next_s;

`ifdef NAND_SEQ_OPSEL_EN
    localparam logic [1:0] OP_NAND = 2'b00;
    localparam logic [1:0] OP_AND  = 2'b01;
    localparam logic [1:0] OP_OR   = 2'b10;
    localparam logic [1:0] OP_XOR  = 2'b11;

    // Where the gate output of the current step is stored.
    typedef enum logic [1:0] {
        DST_T1 = 2'd0,
        DST_T2 = 2'd1,
        DST_T3 = 2'd2,
        DST_R  = 2'd3
    } dst_t;

    logic [1:0] op_r;
    logic       t1_r;
    logic       t2_r;
    logic       t3_r;
    dst_t       dst_s;
`endif

    // idx only ever spans 0..W-1, so these selects stay in range for any W.
    assign bit_a_s = a_r[idx_r];
    assign bit_b_s = b_r[idx_r];

    nand_gate u_gate (
        .x (gate_x_s),
        .y (gate_y_s),
        .z (gate_z_s)
    );

`ifdef NAND_SEQ_OPSEL_EN
    // Per-op microcode: gate input steering, destination and last-step flag.
    always_comb begin
        gate_x_s    = bit_a_s;
        gate_y_s    = bit_b_s;
        dst_s       = DST_R;
        last_step_s = 1'b1;
        case (op_r)
            OP_NAND: begin
                // r = nand(a,b) uses the defaults
            end
            OP_AND: begin
                case (step_r)
                    2'd0: begin
                        dst_s       = DST_T1;
                        last_step_s = 1'b0;
                    end
                    default: begin
                        gate_x_s = t1_r;
                        gate_y_s = t1_r;
                    end
                endcase
            end
            OP_OR: begin
                case (step_r)
                    2'd0: begin
                        gate_y_s    = bit_a_s;
                        dst_s       = DST_T1;
                        last_step_s = 1'b0;
                    end
                    2'd1: begin
                        gate_x_s    = bit_b_s;
                        dst_s       = DST_T2;
                        last_step_s = 1'b0;
                    end
                    default: begin
                        gate_x_s = t1_r;
                        gate_y_s = t2_r;
                    end
                endcase
            end
            OP_XOR: begin
                case (step_r)
                    2'd0: begin
                        dst_s       = DST_T1;
                        last_step_s = 1'b0;
                    end
                    2'd1: begin
                        gate_y_s    = t1_r;
                        dst_s       = DST_T2;
                        last_step_s = 1'b0;
                    end
                    2'd2: begin
                        gate_x_s    = bit_b_s;
                        gate_y_s    = t1_r;
                        dst_s       = DST_T3;
                        last_step_s = 1'b0;
                    end
                    default: begin
                        gate_x_s = t2_r;
                        gate_y_s = t3_r;
                    end
                endcase
            end
            default: begin
                // unreachable: all op encodings are covered above
            end
        endcase
    end
`else
    // NAND only: every bit is a single step straight from the operands.
    always_comb begin
        gate_x_s    = bit_a_s;
        gate_y_s    = bit_b_s;
        last_step_s = (step_r == 2'd0);
    end
`endif

    // Shadow result with the current bit replaced by the gate output; this is
    // what gets committed on the last step of a bit (and copied out on bit W-1).
    always_comb begin
        shadow_next_s        = shadow_r;
        shadow_next_s[idx_r] = gate_z_s;
    end

    // Sequencer FSM together with the operand, index, temp and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            a_r      <= {W{1'b0}};
            b_r      <= {W{1'b0}};
            idx_r    <= {IDX_W{1'b0}};
            step_r   <= 2'd0;
            shadow_r <= {W{1'b0}};
            result_r <= {W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
`ifdef NAND_SEQ_OPSEL_EN
            op_r     <= 2'b00;
            t1_r     <= 1'b0;
            t2_r     <= 1'b0;
            t3_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
`ifdef NAND_SEQ_OPSEL_EN
                        op_r    <= op;
`endif
                        idx_r   <= {IDX_W{1'b0}};
                        step_r  <= 2'd0;
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
`ifdef NAND_SEQ_OPSEL_EN
                    case (dst_s)
                        DST_T1:  t1_r <= gate_z_s;
                        DST_T2:  t2_r <= gate_z_s;
                        DST_T3:  t3_r <= gate_z_s;
                        default: begin
                            // DST_R: written through shadow_next_s below
                        end
                    endcase
`endif
                    if (last_step_s) begin
                        shadow_r <= shadow_next_s;
                        step_r   <= 2'd0;
                        if (idx_r == IDX_LAST) begin
                            idx_r    <= {IDX_W{1'b0}};
                            result_r <= shadow_next_s;
                            busy_r   <= 1'b0;
                            done_r   <= 1'b1;
                            state_r  <= ST_DONE;
                        end else begin
                            idx_r    <= idx_r + IDX_W'(1);
                        end
                    end else begin
                        step_r <= step_r + 2'd1;
                    end
                end
                ST_DONE: begin
                    // start is deliberately not sampled here
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

    nand_serial_seq_chk u_chk (
        .clk  (clk),
        .rst  (rst),
        .busy (busy_r),
        .done (done_r)
    );

endmodule

// File: tb/tb_nand_serial_seq.sv
// Directed self-checking bench for nand_serial_seq (W=4, W=1 and W=32).
module tb_nand_serial_seq;

    logic        clk;
    logic        rst;
    logic        start4, start1, start32;
    logic [3:0]  a4, b4;
    logic [0:0]  a1, b1;
    logic [31:0] a32, b32;
    logic        busy4, busy1, busy32;
    logic        done4, done1, done32;
    logic [3:0]  result4;
    logic [0:0]  result1;
    logic [31:0] result32;
`ifdef NAND_SEQ_OPSEL_EN
    logic [1:0]  op;
`endif

    int tests_run;
    int tests_failed;

    nand_serial_seq #(.W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
`ifdef NAND_SEQ_OPSEL_EN
        .op(op),
`endif
        .busy(busy4), .done(done4), .result(result4)
    );

    nand_serial_seq #(.W(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
`ifdef NAND_SEQ_OPSEL_EN
        .op(op),
`endif
        .busy(busy1), .done(done1), .result(result1)
    );

    nand_serial_seq #(.W(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32),
`ifdef NAND_SEQ_OPSEL_EN
        .op(op),
`endif
        .busy(busy32), .done(done32), .result(result32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sel_done(input int sel);
        case (sel)
            0:       return done4;
            1:       return done1;
            default: return done32;
        endcase
    endfunction

    function automatic logic [31:0] sel_result(input int sel);
        case (sel)
            0:       return {28'd0, result4};
            1:       return {31'd0, result1};
            default: return result32;
        endcase
    endfunction

    // Start one operation on the selected DUT, measure edges from capture to
    // done, then check latency and result and let the DUT return to idle.
    task automatic run_op(input string tag, input int sel, input logic [31:0] av,
                          input logic [31:0] bv, input int exp_lat, input logic [31:0] exp_res);
        int n;
        case (sel)
            0: begin a4 = av[3:0]; b4 = bv[3:0]; start4 = 1'b1; end
            1: begin a1 = av[0:0]; b1 = bv[0:0]; start1 = 1'b1; end
            default: begin a32 = av; b32 = bv; start32 = 1'b1; end
        endcase
        tick();
        start4 = 1'b0; start1 = 1'b0; start32 = 1'b0;
        n = 0;
        while (!sel_done(sel) && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_res"}, sel_result(sel), exp_res);
        tick();
    endtask

    initial begin
        int done_seen;
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1;
        start4 = 1'b1; start1 = 1'b1; start32 = 1'b1;
        a4 = 4'd0; b4 = 4'd0; a1 = 1'b0; b1 = 1'b0; a32 = 32'd0; b32 = 32'd0;
`ifdef NAND_SEQ_OPSEL_EN
        op = 2'b00;
`endif

        // Reset held two cycles with start high
        tick();
        tick();
        check("rst_busy4", {31'd0, busy4}, 32'd0);
        check("rst_done4", {31'd0, done4}, 32'd0);
        check("rst_res4", {28'd0, result4}, 32'd0);
        check("rst_busy32", {31'd0, busy32}, 32'd0);
        check("rst_res32", result32, 32'd0);
        rst = 1'b0;
        start4 = 1'b0; start1 = 1'b0; start32 = 1'b0;
        tick();
        check("post_rst_idle", {31'd0, busy4}, 32'd0);

        // NAND W=4: 1100 nand 1010 = 0111, busy four cycles
        a4 = 4'b1100; b4 = 4'b1010; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("nand_busy_e0", {31'd0, busy4}, 32'd1);
        check("nand_done_e0", {31'd0, done4}, 32'd0);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("nand_busy_run", {31'd0, busy4}, 32'd1);
        end
        tick();
        check("nand_busy_e4", {31'd0, busy4}, 32'd0);
        check("nand_done_e4", {31'd0, done4}, 32'd1);
        check("nand_res_e4", {28'd0, result4}, 32'h7);
        tick();
        check("nand_done_e5", {31'd0, done4}, 32'd0);
        check("nand_hold_e5", {28'd0, result4}, 32'h7);

        // Ignore-while-busy: start held high, operands changed mid-run
        a4 = 4'b0011; b4 = 4'b0101; start4 = 1'b1;
        tick();                                  // edge 0: capture
        tick();                                  // edge 1
        a4 = 4'b1111; b4 = 4'b0000;
        tick(); tick(); tick();                  // edges 2..4
        check("ign_done_e4", {31'd0, done4}, 32'd1);
        check("ign_res_e4", {28'd0, result4}, 32'he);
        tick();                                  // edge 5: DONE -> IDLE
        check("ign_busy_e5", {31'd0, busy4}, 32'd0);
        tick();                                  // edge 6: second capture
        start4 = 1'b0;
        check("ign_busy_e6", {31'd0, busy4}, 32'd1);
        check("ign_hold_e6", {28'd0, result4}, 32'he);
        tick(); tick(); tick(); tick();          // edges 7..10
        check("ign_done_e10", {31'd0, done4}, 32'd1);
        check("ign_res_e10", {28'd0, result4}, 32'hf);
        tick();

        // Reset mid-operation at edge 2 of RUN
        a4 = 4'b0000; b4 = 4'b0000; start4 = 1'b1;
        tick();                                  // edge 0
        start4 = 1'b0;
        tick();                                  // edge 1
        rst = 1'b1;
        tick();                                  // edge 2: reset
        rst = 1'b0;
        check("mrst_busy", {31'd0, busy4}, 32'd0);
        check("mrst_done", {31'd0, done4}, 32'd0);
        check("mrst_res", {28'd0, result4}, 32'd0);
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done4 || busy4) done_seen++;
        end
        check("mrst_no_done", done_seen, 32'd0);

        // Width corners
        run_op("w1_ones", 1, 32'h1, 32'h1, 1, 32'h0);
        run_op("w1_zeros", 1, 32'h0, 32'h0, 1, 32'h1);
        run_op("w32_ones", 2, 32'hffff_ffff, 32'hffff_ffff, 32, 32'h0);
        run_op("w32_zeros", 2, 32'h0, 32'h0, 32, 32'hffff_ffff);
        run_op("w4_mixed", 0, 32'h6, 32'h3, 4, 32'hd);

`ifdef NAND_SEQ_OPSEL_EN
        op = 2'b01;
        run_op("and4", 0, 32'hc, 32'ha, 8, 32'h8);
        op = 2'b10;
        run_op("or4", 0, 32'hc, 32'ha, 12, 32'he);
        op = 2'b11;
        run_op("xor4", 0, 32'hc, 32'ha, 16, 32'h6);
        run_op("xor32", 2, 32'hf0f0_1234, 32'h0ff0_ffff, 128, 32'hff00_edcb);
        op = 2'b00;
        run_op("nand4_op", 0, 32'hc, 32'ha, 4, 32'h7);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
